tpu_tile_sequencer: RTL and testbench

// - Sequences one matrix tile through the TPU datapath: weight FIFO pop, systolic weight reload,

---
 rtl/tpu_tile_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_tpu_tile_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer: weight FIFO pop, array weight reload, UB streaming and result write addressing.
// Optional cycle counter output perf_cycles enabled by defining TPU_SEQ_PERF_EN.
module tpu_tile_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int NUM_PE_ROWS = 8,
  parameter int PIPE_LAT    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] num_vec,
  input  logic [ADDRESSSIZE-1:0] in_base,
  input  logic [ADDRESSSIZE-1:0] out_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_en,
  output logic                   we_rl,
  output logic                   ub_rd,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
`ifdef TPU_SEQ_PERF_EN
  output logic [15:0]            perf_cycles,
`endif
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    RELOAD = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [ADDRESSSIZE-1:0] RELOAD_LAST = ADDRESSSIZE'(NUM_PE_ROWS - 1);

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] cnt_q, cnt_d;
  logic [ADDRESSSIZE-1:0] num_vec_q, num_vec_d;
  logic [ADDRESSSIZE-1:0] in_base_q, in_base_d;
  logic [ADDRESSSIZE-1:0] out_base_q, out_base_d;
  logic [ADDRESSSIZE-1:0] res_cnt_q, res_cnt_d;
  logic [PIPE_LAT-1:0]    dl_q, dl_d;
  logic                   fifo_read_en_q, fifo_read_en_d;
  logic                   we_rl_q, we_rl_d;
  logic                   ub_rd_q, ub_rd_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
  logic                   res_we_q, res_we_d;
  logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef TPU_SEQ_PERF_EN
  logic [15:0]            perf_q, perf_d;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    num_vec_d      = num_vec_q;
    in_base_d      = in_base_q;
    out_base_d     = out_base_q;
    res_cnt_d      = res_cnt_q;
    fifo_read_en_d = 1'b0;
    we_rl_d        = 1'b0;
    ub_rd_d        = 1'b0;
    ub_addr_d      = ub_addr_q;
    res_addr_d     = res_addr_q;
    busy_d         = (state_q != IDLE);
    done_d         = 1'b0;

    // The last delay-line stage is the registered result write strobe.
    res_we_d = dl_q[PIPE_LAT-1];
    if (res_we_d) begin
      res_addr_d = out_base_q + res_cnt_q;
      res_cnt_d  = res_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          num_vec_d  = num_vec;
          in_base_d  = in_base;
          out_base_d = out_base;
          cnt_d      = '0;
          res_cnt_d  = '0;
          // An empty tile passes through an empty DRAIN, so done lands two cycles after start.
          state_d    = (num_vec == '0) ? DRAIN : WAIT_W;
        end
      end
      WAIT_W: begin
        if (!fifo_empty) begin
          fifo_read_en_d = 1'b1;
          state_d        = RELOAD;
        end
      end
      RELOAD: begin
        we_rl_d = 1'b1;
        if (cnt_q == RELOAD_LAST) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        ub_rd_d   = 1'b1;
        ub_addr_d = in_base_q + cnt_q;
        if (cnt_q == num_vec_q - 1'b1) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dl_q[PIPE_LAT-2:0] == '0) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dl_d = {dl_q[PIPE_LAT-2:0], ub_rd_d};

    if (abort) begin
      state_d        = IDLE;
      num_vec_d      = num_vec_q;
      in_base_d      = in_base_q;
      out_base_d     = out_base_q;
      fifo_read_en_d = 1'b0;
      we_rl_d        = 1'b0;
      ub_rd_d        = 1'b0;
      ub_addr_d      = ub_addr_q;
      res_we_d       = 1'b0;
      res_addr_d     = res_addr_q;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      dl_d           = '0;
    end
  end

`ifdef TPU_SEQ_PERF_EN
  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && start && !abort) begin
      perf_d = '0;
    end else if ((state_q != IDLE || busy_q) && perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      num_vec_q      <= '0;
      in_base_q      <= '0;
      out_base_q     <= '0;
      res_cnt_q      <= '0;
      dl_q           <= '0;
      fifo_read_en_q <= 1'b0;
      we_rl_q        <= 1'b0;
      ub_rd_q        <= 1'b0;
      ub_addr_q      <= '0;
      res_we_q       <= 1'b0;
      res_addr_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef TPU_SEQ_PERF_EN
      perf_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      num_vec_q      <= num_vec_d;
      in_base_q      <= in_base_d;
      out_base_q     <= out_base_d;
      res_cnt_q      <= res_cnt_d;
      dl_q           <= dl_d;
      fifo_read_en_q <= fifo_read_en_d;
      we_rl_q        <= we_rl_d;
      ub_rd_q        <= ub_rd_d;
      ub_addr_q      <= ub_addr_d;
      res_we_q       <= res_we_d;
      res_addr_q     <= res_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef TPU_SEQ_PERF_EN
      perf_q         <= perf_d;
`endif
    end
  end

  assign fifo_read_en = fifo_read_en_q;
  assign we_rl        = we_rl_q;
  assign ub_rd        = ub_rd_q;
  assign ub_addr      = ub_addr_q;
  assign res_we       = res_we_q;
  assign res_addr     = res_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef TPU_SEQ_PERF_EN
  assign perf_cycles  = perf_q;
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: directed corner tiles plus random tiles against a timeline model.
// Checks perf_cycles too when TPU_SEQ_PERF_EN is defined.
module tb_tpu_tile_sequencer;
  localparam int ROWS = 8;
  localparam int LAT  = 24;

  logic       clk = 1'b0;
  logic       rst, start, abort, fifo_empty;
  logic [9:0] num_vec, in_base, out_base;
  logic       fifo_read_en, we_rl, ub_rd, res_we, busy, done;
  logic [9:0] ub_addr, res_addr;
`ifdef TPU_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_ub_addr, exp_res_addr;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(.ADDRESSSIZE(10), .NUM_PE_ROWS(ROWS), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_vec(num_vec), .in_base(in_base), .out_base(out_base),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en), .we_rl(we_rl),
    .ub_rd(ub_rd), .ub_addr(ub_addr), .res_we(res_we), .res_addr(res_addr),
    .busy(busy),
`ifdef TPU_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected waveform is a timeline relative to the start edge: pop at s+1, reload for ROWS
  // cycles, n reads, writes LAT cycles after each read, done after the final write.
  task automatic run_tile(input int n, input logic [9:0] inb, input logic [9:0] outb,
                          input int s, input int a, input bit use_rst, input bit glitch,
                          input string name);
    int         done_t, last_t;
    bit         ab, live;
    logic [5:0] exp_v, obs_v;
    done_t = (n > 0) ? s + ROWS + 2 + n + LAT : 2;
    last_t = (a >= 0) ? a + 4 : done_t + 3;
    num_vec    = n[9:0];
    in_base    = inb;
    out_base   = outb;
    start      = 1'b1;
    fifo_empty = (s > 0);
    for (int t = 0; t <= last_t; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      ab    = (a >= 0) && (t >= a);
      live  = !ab && (n > 0);
      exp_v = {live && t == s + 1,
               live && t >= s + 2 && t <= s + ROWS + 1,
               live && t >= s + ROWS + 2 && t <= s + ROWS + 1 + n,
               live && t >= s + ROWS + 2 + LAT && t <= s + ROWS + 1 + LAT + n,
               !ab && t >= 1 && t <= done_t,
               !ab && t == done_t};
      if (ab && use_rst) begin
        exp_ub_addr  = '0;
        exp_res_addr = '0;
      end
      if (exp_v[3]) exp_ub_addr  = inb  + 10'(t - (s + ROWS + 2));
      if (exp_v[2]) exp_res_addr = outb + 10'(t - (s + ROWS + 2 + LAT));
      obs_v = {fifo_read_en, we_rl, ub_rd, res_we, busy, done};
      chk($sformatf("%s c%0d strobes(pop,rl,rd,we,busy,done)", name, t), 16'(obs_v), 16'(exp_v));
      chk($sformatf("%s c%0d ub_addr", name, t), 16'(ub_addr), 16'(exp_ub_addr));
      chk($sformatf("%s c%0d res_addr", name, t), 16'(res_addr), 16'(exp_res_addr));
      fifo_empty = (t < s);
      if (a >= 0 && t + 1 == a) begin
        if (use_rst) rst = 1'b1;
        else         abort = 1'b1;
      end
      if (glitch && t == s + 3) begin
        start    = 1'b1;
        num_vec  = 10'($urandom_range(1, 1023));
        in_base  = 10'($urandom);
        out_base = 10'($urandom);
      end
    end
`ifdef TPU_SEQ_PERF_EN
    if (a < 0) chk($sformatf("%s perf_cycles", name), perf_cycles, 16'(done_t + 1));
`endif
    $display("tile %s n=%0d in=%h out=%h stall=%0d checks=%0d failures=%0d",
             name, n, inb, outb, s, checks, failures);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_empty = 1'b1;
    num_vec = '0; in_base = '0; out_base = '0;
    exp_ub_addr = '0; exp_res_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset strobes", 16'({fifo_read_en, we_rl, ub_rd, res_we, busy, done}), 16'h0);
    chk("reset ub_addr", 16'(ub_addr), 16'h0);
    chk("reset res_addr", 16'(res_addr), 16'h0);
`ifdef TPU_SEQ_PERF_EN
    chk("reset perf_cycles", perf_cycles, 16'h0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_tile(4, 10'h010, 10'h040, 0, -1, 1'b0, 1'b0, "nominal");
    run_tile(4, 10'h010, 10'h040, 5, -1, 1'b0, 1'b0, "stall5");
    run_tile(3, 10'h3FF, 10'h3FE, 0, -1, 1'b0, 1'b0, "wrap");
    run_tile(0, 10'h123, 10'h234, 0, -1, 1'b0, 1'b0, "empty");
    run_tile(5, 10'h080, 10'h0C0, 1, -1, 1'b0, 1'b1, "start_in_reload");
    run_tile(6, 10'h100, 10'h200, 2, 2 + ROWS + 4, 1'b0, 1'b0, "abort");
    run_tile(6, 10'h100, 10'h200, 0, ROWS + 4, 1'b1, 1'b0, "rst");
    run_tile(4, 10'h010, 10'h040, 0, -1, 1'b0, 1'b0, "after_rst");

    // Start together with abort must be ignored.
    num_vec = 10'd4; start = 1'b1; abort = 1'b1; fifo_empty = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk($sformatf("start_abort c%0d strobes", t),
          16'({fifo_read_en, we_rl, ub_rd, res_we, busy, done}), 16'h0);
    end

    for (int r = 0; r < 10; r++) begin
      run_tile($urandom_range(1, 40), 10'($urandom), 10'($urandom),
               $urandom_range(0, 4), -1, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
